// File: rtl/prog_updown_counter_pkg.sv
// Shared constants for the programmable up/down counter.
// Direction and bound-mode encodings used by the top and the next-value logic.
package prog_updown_counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/prog_updown_counter_if.sv
// Control/status bundle of the programmable up/down counter.
// The master drives the controls; the slave (the counter) drives the status.
interface prog_updown_counter_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4
);

  logic              load_en;
  logic [WIDTH-1:0]  data_in;
  logic              count_en;
  logic              up_dn;
  logic              sat_mode;
  logic [WIDTH-1:0]  limit;
  logic [STEP_W-1:0] step;
  logic              clr_flags;
  logic [WIDTH-1:0]  count_out;
  logic              tc;
  logic              ovf;
  logic              unf;

  modport master (
    output load_en, data_in, count_en, up_dn, sat_mode, limit, step, clr_flags,
    input  count_out, tc, ovf, unf
  );

  modport slave (
    input  load_en, data_in, count_en, up_dn, sat_mode, limit, step, clr_flags,
    output count_out, tc, ovf, unf
  );

endinterface

// File: rtl/prog_counter_next.sv
// Combinational next-count computation for one count step.
// Works in WIDTH+1 bits so sums and limit+1 never lose a carry.
module prog_counter_next
  import prog_updown_counter_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4
) (
  input  logic [WIDTH-1:0]  i_count,
  input  logic [WIDTH-1:0]  i_limit,
  input  logic [STEP_W-1:0] i_step,
  input  logic              i_up_dn,
  input  logic              i_sat_mode,
  output logic [WIDTH-1:0]  o_next,
  output logic              o_ovf_evt,
  output logic              o_unf_evt
);

  localparam int unsigned XW = WIDTH + 1;

  logic [XW-1:0] w_cnt;
  logic [XW-1:0] w_lim;
  logic [XW-1:0] w_l1;
  logic [XW-1:0] w_stp;
  logic [XW-1:0] w_sum;
  logic [XW-1:0] w_wrap_up;
  logic [XW-1:0] w_wrap_dn_base;
  logic [XW-1:0] w_res;

  always_comb begin
    w_cnt          = {1'b0, i_count};
    w_lim          = {1'b0, i_limit};
    w_l1           = w_lim + XW'(1);
    w_stp          = XW'(i_step);
    w_sum          = w_cnt + w_stp;
    w_wrap_up      = w_sum - w_l1;
    // cnt <= limit on this path, so cnt + limit + 1 still fits in XW bits
    w_wrap_dn_base = w_cnt + w_l1;
    w_res          = w_cnt;
    o_ovf_evt      = 1'b0;
    o_unf_evt      = 1'b0;

    if (w_stp == '0) begin
      w_res = w_cnt;
    end else if (i_up_dn == DIR_UP) begin
      if ((w_cnt > w_lim) || (w_sum > w_lim)) begin
        o_ovf_evt = 1'b1;
        if (i_sat_mode == MODE_SAT) begin
          w_res = w_lim;
        end else if ((w_cnt <= w_lim) && (w_wrap_up <= w_lim)) begin
          w_res = w_wrap_up;
        end else begin
          w_res = '0;
        end
      end else begin
        w_res = w_sum;
      end
    end else begin
      if (w_cnt > w_lim) begin
        w_res = w_lim;
      end else if (w_stp > w_cnt) begin
        o_unf_evt = 1'b1;
        if (i_sat_mode == MODE_SAT) begin
          w_res = '0;
        end else if (w_wrap_dn_base < w_stp) begin
          w_res = '0;
        end else begin
          w_res = w_wrap_dn_base - w_stp;
        end
      end else begin
        w_res = w_cnt - w_stp;
      end
    end

    o_next = w_res[WIDTH-1:0];
  end

endmodule

// File: rtl/prog_updown_counter.sv
// Programmable up/down counter with limit, step, wrap/saturate and sticky flags.
// Holds the registers; priority is reset > load > count > hold.
module prog_updown_counter
  import prog_updown_counter_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4
) (
  input logic                  clk,
  input logic                  reset_n,
  prog_updown_counter_if.slave bus
);

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_ovf;
  logic             r_unf;

  logic [WIDTH-1:0] w_next;
  logic             w_ovf_evt;
  logic             w_unf_evt;
  logic [WIDTH-1:0] w_count_d;
  logic             w_tc_d;
  logic             w_ovf_d;
  logic             w_unf_d;

  prog_counter_next #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_next (
    .i_count    (r_count),
    .i_limit    (bus.limit),
    .i_step     (bus.step),
    .i_up_dn    (bus.up_dn),
    .i_sat_mode (bus.sat_mode),
    .o_next     (w_next),
    .o_ovf_evt  (w_ovf_evt),
    .o_unf_evt  (w_unf_evt)
  );

  always_comb begin
    w_count_d = r_count;
    w_tc_d    = 1'b0;
    w_ovf_d   = r_ovf & ~bus.clr_flags;
    w_unf_d   = r_unf & ~bus.clr_flags;
    if (bus.load_en) begin
      w_count_d = (bus.data_in > bus.limit) ? bus.limit : bus.data_in;
    end else if (bus.count_en) begin
      w_count_d = w_next;
      w_tc_d    = w_ovf_evt | w_unf_evt;
      // A new event outranks a simultaneous clear
      w_ovf_d   = w_ovf_d | w_ovf_evt;
      w_unf_d   = w_unf_d | w_unf_evt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_count <= w_count_d;
      r_tc    <= w_tc_d;
      r_ovf   <= w_ovf_d;
      r_unf   <= w_unf_d;
    end
  end

  assign bus.count_out = r_count;
  assign bus.tc        = r_tc;
  assign bus.ovf       = r_ovf;
  assign bus.unf       = r_unf;

endmodule

// File: tb/tb_prog_updown_counter.sv
// Directed bench for prog_updown_counter (WIDTH=8, STEP_W=4).
// Each step drives inputs, takes one edge, and checks outputs against hand-computed values.
module tb_prog_updown_counter;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  prog_updown_counter_if #(.WIDTH(8), .STEP_W(4)) u_if ();

  prog_updown_counter #(
    .WIDTH  (8),
    .STEP_W (4)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check count, tc, ovf, unf in one call
  task automatic check_all(input string tag, input logic [7:0] c, input logic t,
                           input logic o, input logic u);
    check_eq({tag, ".count"}, 32'(u_if.count_out), 32'(c));
    check_eq({tag, ".tc"},    32'(u_if.tc),        32'(t));
    check_eq({tag, ".ovf"},   32'(u_if.ovf),       32'(o));
    check_eq({tag, ".unf"},   32'(u_if.unf),       32'(u));
  endtask

  task automatic do_load(input logic [7:0] d);
    u_if.load_en = 1'b1;
    u_if.data_in = d;
    tick();
    u_if.load_en = 1'b0;
  endtask

  task automatic do_clear();
    u_if.count_en  = 1'b0;
    u_if.clr_flags = 1'b1;
    tick();
    u_if.clr_flags = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n        = 1'b0;
    u_if.load_en   = 1'b0;
    u_if.data_in   = 8'h00;
    u_if.count_en  = 1'b1;
    u_if.up_dn     = 1'b1;
    u_if.sat_mode  = 1'b0;
    u_if.limit     = 8'hFF;
    u_if.step      = 4'd1;
    u_if.clr_flags = 1'b0;

    // 1. reset then count by one
    tick();
    tick();
    check_all("rst", 8'h00, 0, 0, 0);
    reset_n = 1'b1;
    tick(); check_all("s1a", 8'h01, 0, 0, 0);
    tick(); check_all("s1b", 8'h02, 0, 0, 0);
    tick(); check_all("s1c", 8'h03, 0, 0, 0);

    // 2. limit 9, step 3, wrap
    u_if.count_en = 1'b0;
    u_if.limit    = 8'h09;
    do_load(8'h00);
    check_all("s2ld", 8'h00, 0, 0, 0);
    u_if.step     = 4'd3;
    u_if.count_en = 1'b1;
    tick(); check_all("s2a", 8'h03, 0, 0, 0);
    tick(); check_all("s2b", 8'h06, 0, 0, 0);
    tick(); check_all("s2c", 8'h09, 0, 0, 0);
    tick(); check_all("s2d", 8'h02, 1, 1, 0);
    tick(); check_all("s2e", 8'h05, 0, 1, 0);
    do_clear();
    check_all("s2clr", 8'h05, 0, 0, 0);

    // step 0 holds with no flags
    u_if.step     = 4'd0;
    u_if.count_en = 1'b1;
    tick(); check_all("step0", 8'h05, 0, 0, 0);

    // 3. saturate at FF
    u_if.count_en = 1'b0;
    u_if.sat_mode = 1'b1;
    u_if.limit    = 8'hFF;
    u_if.step     = 4'd1;
    do_load(8'hFE);
    check_all("s3ld", 8'hFE, 0, 0, 0);
    u_if.count_en = 1'b1;
    tick(); check_all("s3a", 8'hFF, 0, 0, 0);
    tick(); check_all("s3b", 8'hFF, 1, 1, 0);
    tick(); check_all("s3c", 8'hFF, 1, 1, 0);
    u_if.sat_mode = 1'b0;
    tick(); check_all("s3wrap", 8'h00, 1, 1, 0);
    do_clear();
    check_all("s3clr", 8'h00, 0, 0, 0);

    // limit 0: every up count overflows to 0
    u_if.limit    = 8'h00;
    u_if.count_en = 1'b1;
    tick(); check_all("lim0", 8'h00, 1, 1, 0);
    do_clear();

    // 4. down, wrap, limit 9, step 2 from 01
    u_if.limit = 8'h09;
    u_if.up_dn = 1'b0;
    do_load(8'h01);
    check_all("s4ld", 8'h01, 0, 0, 0);
    u_if.step     = 4'd2;
    u_if.count_en = 1'b1;
    tick(); check_all("s4a", 8'h09, 1, 0, 1);
    tick(); check_all("s4b", 8'h07, 0, 0, 1);
    tick(); check_all("s4c", 8'h05, 0, 0, 1);
    do_clear();
    check_all("s4clr", 8'h05, 0, 0, 0);

    // down with count above a lowered limit snaps to limit, no flags
    u_if.limit    = 8'h03;
    u_if.count_en = 1'b1;
    tick(); check_all("dnsnap", 8'h03, 0, 0, 0);

    // down saturate underflow
    u_if.sat_mode = 1'b1;
    u_if.step     = 4'd5;
    tick(); check_all("dnsat", 8'h00, 1, 0, 1);
    u_if.sat_mode = 1'b0;
    do_clear();

    // 5. load clamps to limit; load beats count
    u_if.count_en = 1'b0;
    u_if.limit    = 8'h20;
    do_load(8'h38);
    check_all("s5clamp", 8'h20, 0, 0, 0);
    u_if.count_en = 1'b1;
    u_if.up_dn    = 1'b1;
    u_if.step     = 4'd1;
    do_load(8'h05);
    check_all("s5prio", 8'h05, 0, 0, 0);

    // 6. set ovf, then clear collides with a new overflow
    u_if.count_en = 1'b0;
    u_if.limit    = 8'hFF;
    do_load(8'hFE);
    u_if.step     = 4'd4;
    u_if.count_en = 1'b1;
    tick(); check_all("s6set", 8'h02, 1, 1, 0);
    u_if.count_en = 1'b0;
    do_load(8'h42);
    check_all("s6ld", 8'h42, 0, 1, 0);
    u_if.limit     = 8'h43;
    u_if.count_en  = 1'b1;
    u_if.clr_flags = 1'b1;
    tick(); check_all("s6race", 8'h02, 1, 1, 0);
    u_if.clr_flags = 1'b0;
    u_if.limit     = 8'hFF;
    u_if.step      = 4'd1;
    tick(); check_all("s6cnt", 8'h03, 0, 1, 0);
    reset_n = 1'b0;
    tick();
    tick(); check_all("s6rst", 8'h00, 0, 0, 0);
    reset_n = 1'b1;
    tick(); check_all("s6r1", 8'h01, 0, 0, 0);
    tick(); check_all("s6r2", 8'h02, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule

// File: doc/prog_updown_counter.md
Name: prog_updown_counter

Overview:
Next-generation loadable counter: width-parametrised up/down counter with a programmable inclusive upper limit, a programmable step, and a wrap or saturate mode. It reports a terminal-count pulse and sticky overflow/underflow flags. It serves as the general-purpose timer/index counter for datapath and control blocks, replacing the fixed increment-by-one loadable counter.

Parameters:
WIDTH, 8, counter/data/limit width in bits (>=2)
STEP_W, 4, width of the step input (1..WIDTH)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
load_en  input  1  load data_in on the next edge
data_in  input  WIDTH  load value
count_en  input  1  perform one count step on the next edge
up_dn  input  1  direction: 1 = up, 0 = down
sat_mode  input  1  0 = wrap at bounds, 1 = saturate at bounds
limit  input  WIDTH  inclusive upper bound; counting range is 0..limit
step  input  STEP_W  increment/decrement amount
clr_flags  input  1  clear ovf/unf
count_out  output  WIDTH  registered count
tc  output  1  registered one-cycle pulse on a bound event
ovf  output  1  sticky overflow flag
unf  output  1  sticky underflow flag

Behaviour:
- One clock and no internal state machine beyond the registers. All outputs are registered, and all effects appear on count_out/tc/ovf/unf one edge after the sampled inputs.
- Reset is synchronous and active-low. With reset_n=0 at an edge, count_out=0, tc=0, ovf=0 and unf=0. Reset has top priority, including mid-count and over a pending load.
- Priority per edge is: reset > load_en > count_en > hold.
- Load: count_out <= min(data_in, limit). A load never sets tc, ovf or unf.
- count_en=1 with step=0: count holds and no flags change.
- Arithmetic is done in WIDTH+1 bits. L1 = limit+1.
- Up count, overflow condition: count_out > limit OR count_out+step > limit.
  - No overflow: next = count_out+step.
  - Overflow in wrap mode: next = count_out+step-L1 if count_out<=limit and that result is <=limit; otherwise next = 0.
  - Overflow in saturate mode: next = limit.
  - Overflow sets tc=1 for that cycle and sets ovf.
- Down count:
  - If count_out > limit: next = limit. No flags.
  - Else if step > count_out (underflow):
    - Wrap mode: next = count_out+L1-step. If this would be negative, next = 0.
    - Saturate mode: next = 0.
    - Underflow sets tc and unf.
  - Else: next = count_out-step.
- Saturate mode at a bound with count_en held: a bound event occurs every cycle, so tc stays high each cycle and the count holds.
- limit=0: every count produces 0. An up count with step>=1 overflows every cycle.
- tc is low in any cycle without a bound event. It is also low on load, hold and reset cycles.
- Flags: a set in the same cycle as clr_flags wins, so the flag remains 1. Otherwise clr_flags=1 clears both flags.
- limit and step may change on any cycle and take effect on that edge's computation.

Decomposition:
- Shared package holds localparams DIR_UP=1, DIR_DN=0, MODE_WRAP=0 and MODE_SAT=1.
- One natural sub-module: prog_counter_next. It is purely combinational and computes next value, ovf_evt and unf_evt from count, limit, step, up_dn and sat_mode.
- The top level holds the registers, priority logic and flag logic.

Test Plan:
All scenarios use WIDTH=8 and STEP_W=4.
1. Reset held 2 cycles, then count_en=1, up, step=1, limit=FF, wrap -> count_out 00, 01, 02, 03…; tc/ovf/unf stay 0 throughout.
2. limit=09, step=3, up, wrap, start 00 -> 03, 06, 09, 02. tc is high only in the cycle count_out=02, and ovf=1 from then on.
3. Saturate, limit=FF, load FE, then up with step=1 -> FF (tc=0), then FF, FF with tc=1 each cycle and ovf=1. Switching to wrap at FF -> 00.
4. Down, wrap, limit=09, load 01, step=2 -> 09 (tc=1, unf=1), then 07, 05. Pulse clr_flags -> unf=0 next edge.
5. Load 38 with limit=20 -> count_out=20. Then load_en=1 and count_en=1 in the same cycle with data_in=05 -> 05 (the load wins, no step applied).
6. With ovf=1 and count=42, assert clr_flags in the same cycle as a new overflow -> ovf stays 1. Then reset_n=0 for 2 edges mid-count -> count_out=00, tc=0, ovf=0, unf=0. After release, counting resumes 01, 02…
